// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sub_state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor built from two cascaded half subtractors.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1_0;
    logic b1_1;

    half_sub u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1_0)
    );

    half_sub u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b1_1)
    );

    assign bout = b1_0 | b1_1;

endmodule

// File: rtl/half_sub.sv
// Combinational 1-bit half subtractor: d = a - b, bout set when a < b.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B: one shared full-subtractor cell sequenced LSB-first over WIDTH cycles.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sub_state_t       state;
    sub_state_t       next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // The final result MSB comes straight from the cell, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0] res_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             last;
    logic             accept;

    full_sub_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign accept = (state != S_RUN) && start;

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last)  next_state = S_DONE;
            S_DONE:  next_state = start ? S_RUN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            busy <= (next_state == S_RUN);
            done <= (next_state == S_DONE);
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (state == S_RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr <= {cell_d, res_sr[WIDTH-2:1]};
                borrow <= cell_bout;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    diff       <= {cell_d, res_sr};
                    borrow_out <= cell_bout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int n_tests;
    int n_fail;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the negedge of the first cycle after acceptance.
    task automatic pulse_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles (1 = first after acceptance) until done is seen; bounded.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, diff, borrow_out} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        int bcnt;
        pulse_start(8'h05, 8'h03);
        n_tests++;
        if (diff !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_hold_during_run: got diff=%h, want 00", diff);
        end
        wait_done(cyc, bcnt);
        n_tests++;
        if (cyc !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: done at cycle %0d, want 9", cyc);
        end
        n_tests++;
        if (bcnt !== 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
        end
        n_tests++;
        if (diff !== 8'h02 || borrow_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%h borrow=%b busy=%b, want 02 0 0",
                     diff, borrow_out, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_borrow;
        int cyc;
        int bcnt;
        pulse_start(8'h03, 8'h05);
        wait_done(cyc, bcnt);
        n_tests++;
        if (diff !== 8'hFE || borrow_out !== 1'b1 || cyc !== 9) begin
            n_fail++;
            $display("FAIL borrow_result: got diff=%h borrow=%b cyc=%0d, want FE 1 9",
                     diff, borrow_out, cyc);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int bcnt;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        @(negedge clk);
        wait_done(cyc, bcnt);
        n_tests++;
        if (diff !== 8'h00 || borrow_out !== 1'b0 || cyc !== 9) begin
            n_fail++;
            $display("FAIL b2b_first: got diff=%h borrow=%b cyc=%0d, want 00 0 9",
                     diff, borrow_out, cyc);
        end
        a = 8'hFF;
        b = 8'h01;
        @(negedge clk);
        wait_done(cyc, bcnt);
        start = 1'b0;
        n_tests++;
        if (diff !== 8'hFE || borrow_out !== 1'b0 || cyc !== 9 || bcnt !== 8) begin
            n_fail++;
            $display("FAIL b2b_second: got diff=%h borrow=%b gap=%0d busy=%0d, want FE 0 9 8",
                     diff, borrow_out, cyc, bcnt);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_after: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        int bcnt;
        int pulses;
        pulse_start(8'h10, 8'h01);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        n_tests++;
        if (diff !== 8'h0F || borrow_out !== 1'b0 || cyc !== 7) begin
            n_fail++;
            $display("FAIL ignore_result: got diff=%h borrow=%b cyc=%0d, want 0F 0 7",
                     diff, borrow_out, cyc);
        end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL ignore_no_extra_run: got %0d busy/done cycles, want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int bcnt;
        int pulses;
        pulse_start(8'h80, 8'h7F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d done pulses, want 0", pulses);
        end
        pulse_start(8'h80, 8'h7F);
        wait_done(cyc, bcnt);
        n_tests++;
        if (diff !== 8'h01 || borrow_out !== 1'b0 || cyc !== 9) begin
            n_fail++;
            $display("FAIL midrst_restart: got diff=%h borrow=%b cyc=%0d, want 01 0 9",
                     diff, borrow_out, cyc);
        end
    endtask

    task automatic test_random;
        int cyc;
        int bcnt;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [WIDTH:0]   expv;
        for (int i = 0; i < 1000; i++) begin
            av   = WIDTH'($urandom);
            bv   = WIDTH'($urandom);
            expv = {1'b0, av} - {1'b0, bv};
            pulse_start(av, bv);
            wait_done(cyc, bcnt);
            n_tests++;
            if ({borrow_out, diff} !== expv || cyc !== 9) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h got borrow=%b diff=%h cyc=%0d, want %b %h 9",
                         i, av, bv, borrow_out, diff, cyc, expv[WIDTH], expv[WIDTH-1:0]);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        test_reset;
        test_basic;
        test_borrow;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid_run;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
